// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, LSU and memory-port signals around mem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding core/memory.
interface mem_arbiter_if;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_gnt;
  logic        o_if_rvalid;
  logic [31:0] o_if_rdata;
  logic        o_if_err;

  logic        i_ls_req;
  logic [31:0] i_ls_addr;
  logic        i_ls_we;
  logic [1:0]  i_ls_size;
  logic        i_ls_sign_ext;
  logic [31:0] i_ls_wdata;
  logic        o_ls_gnt;
  logic        o_ls_rvalid;
  logic [31:0] o_ls_rdata;
  logic        o_ls_err;

  logic        o_mem_req;
  logic        i_mem_gnt;
  logic [31:0] o_mem_addr;
  logic        o_mem_we;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_wdata;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_stall;

  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_gnt, o_if_rvalid, o_if_rdata, o_if_err,
    input  i_ls_req, i_ls_addr, i_ls_we, i_ls_size, i_ls_sign_ext, i_ls_wdata,
    output o_ls_gnt, o_ls_rvalid, o_ls_rdata, o_ls_err,
    output o_mem_req, o_mem_addr, o_mem_we, o_mem_be, o_mem_wdata,
    input  i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    output o_stall
  );

  modport master (
    output i_if_req, i_if_addr,
    input  o_if_gnt, o_if_rvalid, o_if_rdata, o_if_err,
    output i_ls_req, i_ls_addr, i_ls_we, i_ls_size, i_ls_sign_ext, i_ls_wdata,
    input  o_ls_gnt, o_ls_rvalid, o_ls_rdata, o_ls_err,
    input  o_mem_req, o_mem_addr, o_mem_we, o_mem_be, o_mem_wdata,
    output i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    input  o_stall
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single memory port shared by instruction fetch and the LSU: LSU-priority arbitration,
// request/grant/response sequencing with timeout, byte-lane steering and load extension.
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_WIDTH       = 8
) (
  input logic          i_clk,
  input logic          i_rst_n,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_LS} owner_t;

  state_t                state_q, state_d;
  owner_t                owner_q, owner_d;
  logic [TO_WIDTH-1:0]   cnt_q, cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic [31:0]           mem_addr_q, mem_addr_d;
  logic                  mem_we_q, mem_we_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [1:0]            size_q, size_d;
  logic [1:0]            off_q, off_d;
  logic                  sext_q, sext_d;
  logic                  if_rvalid_q, if_rvalid_d;
  logic                  if_err_q, if_err_d;
  logic [31:0]           if_rdata_q, if_rdata_d;
  logic                  ls_rvalid_q, ls_rvalid_d;
  logic                  ls_err_q, ls_err_d;
  logic [31:0]           ls_rdata_q, ls_rdata_d;

  logic        if_gnt, ls_gnt, ls_bad;
  logic [3:0]  ls_be;
  logic [31:0] ls_wdata, rd_shift, load_data;
  logic        unused_if_addr_lsbs;

  assign unused_if_addr_lsbs = &{1'b0, bus.i_if_addr[1:0]};

  // Request-side decode of the LSU controls.
  always_comb begin
    ls_bad = (bus.i_ls_size == 2'd3) ||
             (bus.i_ls_size == 2'd1 && bus.i_ls_addr[0]) ||
             (bus.i_ls_size == 2'd2 && bus.i_ls_addr[1:0] != 2'b00);
    case (bus.i_ls_size)
      2'd0:    ls_be = 4'b0001 << bus.i_ls_addr[1:0];
      2'd1:    ls_be = 4'b0011 << bus.i_ls_addr[1:0];
      default: ls_be = 4'b1111;
    endcase
    case (bus.i_ls_size)
      2'd0:    ls_wdata = {4{bus.i_ls_wdata[7:0]}};
      2'd1:    ls_wdata = {2{bus.i_ls_wdata[15:0]}};
      default: ls_wdata = bus.i_ls_wdata;
    endcase
  end

  // Response-side lane select and extension, using the size/offset captured at grant.
  always_comb begin
    rd_shift = bus.i_mem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'd0:    load_data = sext_q ? {{24{rd_shift[7]}}, rd_shift[7:0]} : {24'b0, rd_shift[7:0]};
      2'd1:    load_data = sext_q ? {{16{rd_shift[15]}}, rd_shift[15:0]} : {16'b0, rd_shift[15:0]};
      default: load_data = bus.i_mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    size_d      = size_q;
    off_d       = off_q;
    sext_d      = sext_q;
    if_rvalid_d = 1'b0;
    if_err_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rvalid_d = 1'b0;
    ls_err_d    = 1'b0;
    ls_rdata_d  = ls_rdata_q;
    if_gnt      = 1'b0;
    ls_gnt      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_ls_req && i_rst_n) begin
          ls_gnt = 1'b1;
          if (ls_bad) begin
            // Rejected without touching memory; answered next cycle from IDLE.
            ls_rvalid_d = 1'b1;
            ls_err_d    = 1'b1;
            ls_rdata_d  = 32'h0;
          end else begin
            state_d     = REQ;
            owner_d     = OWN_LS;
            mem_req_d   = 1'b1;
            mem_addr_d  = {bus.i_ls_addr[31:2], 2'b00};
            mem_we_d    = bus.i_ls_we;
            mem_be_d    = ls_be;
            mem_wdata_d = ls_wdata;
            size_d      = bus.i_ls_size;
            off_d       = bus.i_ls_addr[1:0];
            sext_d      = bus.i_ls_sign_ext;
          end
        end else if (bus.i_if_req && i_rst_n) begin
          if_gnt      = 1'b1;
          state_d     = REQ;
          owner_d     = OWN_IF;
          mem_req_d   = 1'b1;
          mem_addr_d  = {bus.i_if_addr[31:2], 2'b00};
          mem_we_d    = 1'b0;
          mem_be_d    = 4'b1111;
          mem_wdata_d = 32'h0;
          size_d      = 2'd2;
          off_d       = 2'd0;
          sext_d      = 1'b0;
        end
      end
      REQ: begin
        if (bus.i_mem_gnt) begin
          state_d   = WAIT;
          mem_req_d = 1'b0;
          cnt_d     = '0;
        end
      end
      WAIT: begin
        if (bus.i_mem_rvalid) begin
          state_d = IDLE;
          if (owner_q == OWN_LS) begin
            ls_rvalid_d = 1'b1;
            ls_rdata_d  = mem_we_q ? 32'h0 : load_data;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = bus.i_mem_rdata;
          end
        end else if (cnt_q == TO_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          // This is the TIMEOUT_CYCLES-th silent WAIT cycle.
          state_d = IDLE;
          if (owner_q == OWN_LS) begin
            ls_rvalid_d = 1'b1;
            ls_err_d    = 1'b1;
            ls_rdata_d  = 32'h0;
          end else begin
            if_rvalid_d = 1'b1;
            if_err_d    = 1'b1;
            if_rdata_d  = 32'h0;
          end
        end else begin
          cnt_d = cnt_q + TO_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= 32'h0;
      size_q      <= 2'd0;
      off_q       <= 2'd0;
      sext_q      <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= 32'h0;
      ls_rvalid_q <= 1'b0;
      ls_err_q    <= 1'b0;
      ls_rdata_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      size_q      <= size_d;
      off_q       <= off_d;
      sext_q      <= sext_d;
      if_rvalid_q <= if_rvalid_d;
      if_err_q    <= if_err_d;
      if_rdata_q  <= if_rdata_d;
      ls_rvalid_q <= ls_rvalid_d;
      ls_err_q    <= ls_err_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign bus.o_if_gnt    = if_gnt;
  assign bus.o_if_rvalid = if_rvalid_q;
  assign bus.o_if_rdata  = if_rdata_q;
  assign bus.o_if_err    = if_err_q;
  assign bus.o_ls_gnt    = ls_gnt;
  assign bus.o_ls_rvalid = ls_rvalid_q;
  assign bus.o_ls_rdata  = ls_rdata_q;
  assign bus.o_ls_err    = ls_err_q;
  assign bus.o_mem_req   = mem_req_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_be    = mem_be_q;
  assign bus.o_mem_wdata = mem_wdata_q;
  assign bus.o_stall     = (state_q != IDLE) || if_gnt || ls_gnt;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: priority, lane steering, load extension,
// misalignment rejection, timeout, stray responses and mid-transaction reset.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n;

  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT_CYCLES(255), .TO_WIDTH(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-16s observed %h expected %h", tag, obs, exp);
  endtask

  // One complete LSU access with memory granting and answering immediately.
  task automatic ls_xfer(input string tag, input logic [31:0] addr, input logic we,
                         input logic [1:0] size, input logic sext, input logic [31:0] wdata,
                         input logic [31:0] mrdata, input logic [3:0] exp_be,
                         input logic [31:0] exp_maddr, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_rdata);
    bus.i_ls_req = 1'b1; bus.i_ls_addr = addr; bus.i_ls_we = we;
    bus.i_ls_size = size; bus.i_ls_sign_ext = sext; bus.i_ls_wdata = wdata;
    #1;
    chk({tag, "_gnt"}, {31'b0, bus.o_ls_gnt}, 32'd1);
    tick();
    bus.i_ls_req = 1'b0; bus.i_mem_gnt = 1'b1;
    chk({tag, "_req"}, {31'b0, bus.o_mem_req}, 32'd1);
    chk({tag, "_addr"}, bus.o_mem_addr, exp_maddr);
    chk({tag, "_be"}, {28'b0, bus.o_mem_be}, {28'b0, exp_be});
    chk({tag, "_we"}, {31'b0, bus.o_mem_we}, {31'b0, we});
    if (we) chk({tag, "_wdata"}, bus.o_mem_wdata, exp_wdata);
    tick();
    bus.i_mem_gnt = 1'b0; bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = mrdata;
    chk({tag, "_waitnv"}, {31'b0, bus.o_ls_rvalid}, 32'd0);
    tick();
    bus.i_mem_rvalid = 1'b0;
    chk({tag, "_rvalid"}, {31'b0, bus.o_ls_rvalid}, 32'd1);
    chk({tag, "_rdata"}, bus.o_ls_rdata, exp_rdata);
    chk({tag, "_err"}, {31'b0, bus.o_ls_err}, 32'd0);
    chk({tag, "_stall"}, {31'b0, bus.o_stall}, 32'd0);
  endtask

  task automatic ls_reject(input string tag, input logic [31:0] addr, input logic [1:0] size);
    bus.i_ls_req = 1'b1; bus.i_ls_addr = addr; bus.i_ls_we = 1'b0;
    bus.i_ls_size = size; bus.i_ls_sign_ext = 1'b0;
    #1;
    chk({tag, "_gnt"}, {31'b0, bus.o_ls_gnt}, 32'd1);
    chk({tag, "_stall1"}, {31'b0, bus.o_stall}, 32'd1);
    tick();
    bus.i_ls_req = 1'b0;
    #1;
    chk({tag, "_noreq"}, {31'b0, bus.o_mem_req}, 32'd0);
    chk({tag, "_rvalid"}, {31'b0, bus.o_ls_rvalid}, 32'd1);
    chk({tag, "_err"}, {31'b0, bus.o_ls_err}, 32'd1);
    chk({tag, "_rdata"}, bus.o_ls_rdata, 32'h0);
    chk({tag, "_stall0"}, {31'b0, bus.o_stall}, 32'd0);
    tick();
    chk({tag, "_pulse"}, {31'b0, bus.o_ls_rvalid}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.i_if_req = 1'b0; bus.i_if_addr = 32'h0;
    bus.i_ls_req = 1'b0; bus.i_ls_addr = 32'h0; bus.i_ls_we = 1'b0;
    bus.i_ls_size = 2'd0; bus.i_ls_sign_ext = 1'b0; bus.i_ls_wdata = 32'h0;
    bus.i_mem_gnt = 1'b0; bus.i_mem_rvalid = 1'b0; bus.i_mem_rdata = 32'h0;
    #2;
    chk("rst_ctrl", {23'b0, bus.o_if_gnt, bus.o_if_rvalid, bus.o_if_err, bus.o_ls_gnt,
                     bus.o_ls_rvalid, bus.o_ls_err, bus.o_mem_req, bus.o_mem_we,
                     bus.o_stall}, 32'h0);
    chk("rst_be", {28'b0, bus.o_mem_be}, 32'h0);
    chk("rst_addr", bus.o_mem_addr, 32'h0);
    chk("rst_wdata", bus.o_mem_wdata, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Simultaneous requests: LSU lw at 0x104 wins, fetch at 0x200 follows.
    bus.i_if_req = 1'b1; bus.i_if_addr = 32'h200;
    bus.i_ls_req = 1'b1; bus.i_ls_addr = 32'h104; bus.i_ls_we = 1'b0;
    bus.i_ls_size = 2'd2; bus.i_ls_sign_ext = 1'b0;
    #1;
    chk("pri_ls_gnt", {31'b0, bus.o_ls_gnt}, 32'd1);
    chk("pri_if_gnt", {31'b0, bus.o_if_gnt}, 32'd0);
    chk("pri_stall", {31'b0, bus.o_stall}, 32'd1);
    tick();
    bus.i_ls_req = 1'b0; bus.i_mem_gnt = 1'b1;
    chk("pri_req", {31'b0, bus.o_mem_req}, 32'd1);
    chk("pri_addr", bus.o_mem_addr, 32'h104);
    chk("pri_be", {28'b0, bus.o_mem_be}, 32'hF);
    chk("pri_busy_ifgnt", {31'b0, bus.o_if_gnt}, 32'd0);
    tick();
    bus.i_mem_gnt = 1'b0; bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = 32'h1122_3344;
    chk("pri_wait_req", {31'b0, bus.o_mem_req}, 32'd0);
    chk("pri_wait_stall", {31'b0, bus.o_stall}, 32'd1);
    tick();
    bus.i_mem_rvalid = 1'b0;
    chk("pri_ls_rvalid", {31'b0, bus.o_ls_rvalid}, 32'd1);
    chk("pri_ls_rdata", bus.o_ls_rdata, 32'h1122_3344);
    chk("pri_if_gnt2", {31'b0, bus.o_if_gnt}, 32'd1);
    tick();
    bus.i_if_req = 1'b0; bus.i_mem_gnt = 1'b1;
    chk("if_addr", bus.o_mem_addr, 32'h200);
    chk("if_be_we", {27'b0, bus.o_mem_be, bus.o_mem_we}, {27'b0, 4'hF, 1'b0});
    tick();
    bus.i_mem_gnt = 1'b0; bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = 32'hCAFE_F00D;
    tick();
    bus.i_mem_rvalid = 1'b0;
    chk("if_rvalid", {31'b0, bus.o_if_rvalid}, 32'd1);
    chk("if_rdata", bus.o_if_rdata, 32'hCAFE_F00D);
    chk("if_err", {31'b0, bus.o_if_err}, 32'd0);
    chk("if_ls_quiet", {31'b0, bus.o_ls_rvalid}, 32'd0);
    tick();

    ls_xfer("lb_sx", 32'h203, 1'b0, 2'd0, 1'b1, 32'h0, 32'h80FF_0000, 4'b1000, 32'h200, 32'h0, 32'hFFFF_FF80);
    ls_xfer("lb_zx", 32'h203, 1'b0, 2'd0, 1'b0, 32'h0, 32'h80FF_0000, 4'b1000, 32'h200, 32'h0, 32'h0000_0080);
    ls_xfer("sh", 32'h12, 1'b1, 2'd1, 1'b0, 32'h0000_BEEF, 32'h1234_5678, 4'b1100, 32'h10, 32'hBEEF_BEEF, 32'h0);
    ls_xfer("lh_sx", 32'h0E, 1'b0, 2'd1, 1'b1, 32'h0, 32'h8001_1234, 4'b1100, 32'h0C, 32'h0, 32'hFFFF_8001);
    ls_xfer("lh_zx", 32'h0C, 1'b0, 2'd1, 1'b0, 32'h0, 32'h8001_F234, 4'b0011, 32'h0C, 32'h0, 32'h0000_F234);
    ls_xfer("sb", 32'h5, 1'b1, 2'd0, 1'b0, 32'h0000_00A5, 32'h0, 4'b0010, 32'h4, 32'hA5A5_A5A5, 32'h0);
    ls_xfer("lb1", 32'h31, 1'b0, 2'd0, 1'b1, 32'h0, 32'h0000_7F00, 4'b0010, 32'h30, 32'h0, 32'h0000_007F);

    ls_reject("mis_lw", 32'h101, 2'd2);
    ls_reject("mis_lh", 32'h103, 2'd1);
    ls_reject("rsv_sz", 32'h40, 2'd3);

    // Fetch that memory grants but never answers: 255 silent WAIT cycles.
    bus.i_if_req = 1'b1; bus.i_if_addr = 32'h300;
    #1;
    chk("to_gnt", {31'b0, bus.o_if_gnt}, 32'd1);
    tick();
    bus.i_if_req = 1'b0; bus.i_mem_gnt = 1'b1;
    chk("to_addr", bus.o_mem_addr, 32'h300);
    tick();
    bus.i_mem_gnt = 1'b0;
    n = 1;
    while (bus.o_if_rvalid !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk("to_wait_cycles", n - 1, 32'd255);
    chk("to_err", {31'b0, bus.o_if_err}, 32'd1);
    chk("to_rdata", bus.o_if_rdata, 32'h0);
    chk("to_stall", {31'b0, bus.o_stall}, 32'd0);
    tick();
    bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.i_mem_rvalid = 1'b0;
    chk("stray_if", {31'b0, bus.o_if_rvalid}, 32'd0);
    tick();
    chk("stray_any", {30'b0, bus.o_if_rvalid, bus.o_ls_rvalid}, 32'd0);
    chk("stray_idle", {30'b0, bus.o_mem_req, bus.o_stall}, 32'd0);

    // Reset in the middle of a WAIT, with a fetch request held high.
    bus.i_if_req = 1'b1; bus.i_if_addr = 32'h400;
    #1;
    tick();
    bus.i_if_req = 1'b0; bus.i_mem_gnt = 1'b1;
    tick();
    bus.i_mem_gnt = 1'b0;
    tick();
    chk("mid_stall", {31'b0, bus.o_stall}, 32'd1);
    bus.i_if_req = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mrst_ctrl", {23'b0, bus.o_if_gnt, bus.o_if_rvalid, bus.o_if_err, bus.o_ls_gnt,
                      bus.o_ls_rvalid, bus.o_ls_err, bus.o_mem_req, bus.o_mem_we,
                      bus.o_stall}, 32'h0);
    chk("mrst_addr", bus.o_mem_addr, 32'h0);
    chk("mrst_be", {28'b0, bus.o_mem_be}, 32'h0);
    chk("mrst_ls_rdata", bus.o_ls_rdata, 32'h0);
    bus.i_if_req = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = 32'h5555_AAAA;
    tick();
    bus.i_mem_rvalid = 1'b0;
    chk("post_rst_rv", {30'b0, bus.o_if_rvalid, bus.o_ls_rvalid}, 32'd0);
    chk("post_rst_idle", {30'b0, bus.o_mem_req, bus.o_stall}, 32'd0);
    tick();
    chk("post_rst_rv2", {30'b0, bus.o_if_rvalid, bus.o_ls_rvalid}, 32'd0);

    ls_xfer("post_lw", 32'h20, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0BAD_F00D, 4'b1111, 32'h20, 32'h0, 32'h0BAD_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
